rom_dl_writer: RTL

//  Write-side driver for the download-loaded ROM write port (CL1/AD1/DI1/WE1).

---
 rtl/rom_dl_writer_pkg.sv | 22 ++
 rtl/dl_word_pack.sv | 42 ++++
 rtl/rom_dl_writer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rom_dl_writer_pkg.sv
// Shared definitions for the download-stream ROM writer: state encoding,
// download address width and byte-lane geometry helpers.
package rom_dl_writer_pkg;

  localparam int unsigned DlAw = 25;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} dl_state_e;

  function automatic int unsigned calc_bpw(int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned calc_lb(int unsigned dw);
    return (dw / 8 <= 1) ? 0 : $clog2(dw / 8);
  endfunction

  // Lane index width; never zero so a single-lane build still has a port.
  function automatic int unsigned calc_lw(int unsigned dw);
    return (calc_lb(dw) == 0) ? 1 : calc_lb(dw);
  endfunction

endpackage

// File: rtl/dl_word_pack.sv
// Byte-lane assembly register: clear fills every lane with FILL, load drops one
// byte into its lane. word_nxt shows the word including this cycle's update.
module dl_word_pack #(
  parameter int unsigned DW     = 16,
  parameter int unsigned LW     = 1,
  parameter bit          BIGEND = 1'b1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [LW-1:0] lane,
  input  logic [7:0]    din,
  output logic [DW-1:0] word,
  output logic [DW-1:0] word_nxt
);

  localparam int unsigned Bpw = DW / 8;

  logic [DW-1:0] word_q;
  int unsigned   pos;

  always_comb begin
    pos      = BIGEND ? (Bpw - 1 - 32'(lane)) : 32'(lane);
    word_nxt = clr ? {Bpw{FILL}} : word_q;
    if (ld) begin
      word_nxt[8*pos +: 8] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= {Bpw{FILL}};
    end else begin
      word_q <= word_nxt;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/rom_dl_writer.sv
// Filters the shared HPS download byte stream to this ROM's window, packs the
// bytes into DW-bit words and issues single-cycle writes on the ROM port.
module rom_dl_writer
  import rom_dl_writer_pkg::*;
#(
  parameter int unsigned AW     = 15,
  parameter int unsigned DW     = 16,
  parameter int unsigned BASE   = 0,
  parameter bit          BIGEND = 1'b1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic            cl,
  input  logic            rst,
  input  logic            dl_en,
  input  logic            dl_wr,
  input  logic [DlAw-1:0] dl_ad,
  input  logic [7:0]      dl_dt,
  output logic [AW-1:0]   wad,
  output logic [DW-1:0]   wdt,
  output logic            we,
  output logic [AW:0]     wcnt,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned      Bpw      = calc_bpw(DW);
  localparam int unsigned      Lb       = calc_lb(DW);
  localparam int unsigned      Lw       = calc_lw(DW);
  localparam logic [DlAw:0]    BaseW    = (DlAw + 1)'(BASE);
  localparam logic [DlAw:0]    WinBytes = (DlAw + 1)'(1) << (AW + Lb);
  localparam logic [DlAw:0]    LaneMask = (DlAw + 1)'(Bpw - 1);
  localparam logic [Lw-1:0]    LastLane = Lw'(Bpw - 1);
  localparam logic [AW:0]      WcntMax  = {1'b1, {AW{1'b0}}};

  dl_state_e     state_q, state_d;
  logic          dl_en_q;
  logic [Lw-1:0] lane_q, lane_d;
  logic [AW-1:0] cur_wad_q, cur_wad_d;
  logic [AW-1:0] wad_q, wad_d;
  logic [DW-1:0] wdt_q, wdt_d;
  logic          we_q, we_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          err_q, err_d;

  logic [DlAw:0] off;
  logic          in_win;
  logic [Lw-1:0] b_lane;
  logic [AW-1:0] b_word;

  logic          pk_clr, pk_ld;
  logic [DW-1:0] pk_word, pk_nxt;
  logic          emit, start;
  logic [AW-1:0] emit_wad;
  logic [DW-1:0] emit_dat;

  // Offset is unsigned and wraps, so the explicit >= BASE check rejects bytes below the window.
  assign off    = {1'b0, dl_ad} - BaseW;
  assign in_win = ({1'b0, dl_ad} >= BaseW) && (off < WinBytes);
  assign b_lane = Lw'(off & LaneMask);
  assign b_word = AW'(off >> Lb);

  dl_word_pack #(
    .DW     (DW),
    .LW     (Lw),
    .BIGEND (BIGEND),
    .FILL   (FILL)
  ) u_pack (
    .clk      (cl),
    .rst      (rst),
    .clr      (pk_clr),
    .ld       (pk_ld),
    .lane     (b_lane),
    .din      (dl_dt),
    .word     (pk_word),
    .word_nxt (pk_nxt)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cur_wad_d = cur_wad_q;
    wad_d     = wad_q;
    wdt_d     = wdt_q;
    we_d      = 1'b0;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    pk_clr    = 1'b0;
    pk_ld     = 1'b0;
    emit      = 1'b0;
    emit_wad  = cur_wad_q;
    emit_dat  = pk_nxt;
    start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dl_en) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
      StLoad: begin
        // A byte arriving in the cycle dl_en drops is still taken.
        if (dl_wr && in_win) begin
          if (b_lane == '0) begin
            if (lane_q != '0) err_d = 1'b1;
            pk_clr    = 1'b1;
            pk_ld     = 1'b1;
            cur_wad_d = b_word;
            if (Bpw == 1) begin
              emit     = 1'b1;
              emit_wad = b_word;
              lane_d   = '0;
            end else begin
              lane_d = Lw'(1);
            end
          end else if (b_lane == lane_q && b_word == cur_wad_q) begin
            pk_ld = 1'b1;
            if (b_lane == LastLane) begin
              emit   = 1'b1;
              lane_d = '0;
            end else begin
              lane_d = lane_q + Lw'(1);
            end
          end else begin
            err_d  = 1'b1;
            pk_clr = 1'b1;
            lane_d = '0;
          end
        end
        if (!dl_en) state_d = StFlush;
      end
      StFlush: begin
        if (lane_q != '0) begin
          emit     = 1'b1;
          emit_dat = pk_word;
        end
        lane_d  = '0;
        pk_clr  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (dl_en && !dl_en_q) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
    endcase

    if (start) begin
      err_d  = 1'b0;
      wcnt_d = '0;
      lane_d = '0;
      pk_clr = 1'b1;
    end

    if (emit) begin
      we_d  = 1'b1;
      wad_d = emit_wad;
      wdt_d = emit_dat;
      if (wcnt_q != WcntMax) wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge cl) begin
    if (rst) begin
      state_q   <= StIdle;
      dl_en_q   <= 1'b0;
      lane_q    <= '0;
      cur_wad_q <= '0;
      wad_q     <= '0;
      wdt_q     <= '0;
      we_q      <= 1'b0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_en_q   <= dl_en;
      lane_q    <= lane_d;
      cur_wad_q <= cur_wad_d;
      wad_q     <= wad_d;
      wdt_q     <= wdt_d;
      we_q      <= we_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
    end
  end

  assign wad  = wad_q;
  assign wdt  = wdt_q;
  assign we   = we_q;
  assign wcnt = wcnt_q;
  assign err  = err_q;
  assign busy = (state_q == StLoad) || (state_q == StFlush);
  assign done = (state_q == StDone);

endmodule
